fp_mul_pipe: RTL and testbench



---
 rtl/fp_mul_pipe.sv | 177 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined floating-point multiplier with valid/ready handshake.
//   Operand widths are set by EXP_W/MAN_W (IEEE-754 style {sign, exp, frac}).
//   Subnormal inputs flush to signed zero; results never go subnormal.
//   Rounding is round-to-nearest-even. Results leave in acceptance order.
//   Timing: operands accepted at edge N produce out_valid after edge N+3.
//   The operand register feeds S1, so the multiplier starts from a flop boundary.
//   S1: classify, exponent add, multiply.
//   S2: normalise, round, range check.
//   S3: special-case mux into result/flags.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake (in_ready = !out_valid | out_ready)
//   a, b            operands
//   out_valid/ready result handshake
//   result, flags   product and {invalid, overflow, underflow, inexact}
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // operand register
  logic         s0_valid;
  logic [W-1:0] s0_a, s0_b;

  // S1 combinational: classification
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_frac, b_frac;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [PW-1:0]      sig_a, sig_b;

  assign a_sign = s0_a[W-1];
  assign b_sign = s0_b[W-1];
  assign a_exp  = s0_a[W-2 -: EXP_W];
  assign b_exp  = s0_b[W-2 -: EXP_W];
  assign a_frac = s0_a[MAN_W-1:0];
  assign b_frac = s0_b[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);
  assign a_snan = a_nan && !a_frac[MAN_W-1];
  assign b_snan = b_nan && !b_frac[MAN_W-1];
  assign sig_a  = {{(MAN_W+1){1'b0}}, 1'b1, a_frac};
  assign sig_b  = {{(MAN_W+1){1'b0}}, 1'b1, b_frac};

  // S1 registers
  logic                 s1_valid, s1_sign, s1_nan_out, s1_invalid, s1_inf, s1_zero;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  // S2 combinational: normalise and round
  logic                 prod_msb, guard, sticky, round_up, carry, inexact_n;
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic [MAN_W+1:0]     rsum;
  logic signed [EW-1:0] e1, e2;

  assign prod_msb  = s1_prod[PW-1];
  // Below the hidden bit only; hidden 1 is implicit after normalisation.
  assign norm      = prod_msb ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
  assign e1        = s1_exp + $signed({{(EW-1){1'b0}}, prod_msb});
  assign frac_t    = norm[PW-2 -: MAN_W];
  assign guard     = norm[PW-2-MAN_W];
  assign sticky    = |norm[PW-3-MAN_W:0];
  assign round_up  = guard && (sticky || frac_t[0]);
  assign rsum      = {1'b0, 1'b1, frac_t} + {{(MAN_W+1){1'b0}}, round_up};
  // A carry out of rounding means the significand became exactly 2.0.
  assign carry     = rsum[MAN_W+1];
  assign frac_r    = carry ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
  assign e2        = e1 + $signed({{(EW-1){1'b0}}, carry});
  assign inexact_n = guard || sticky;

  // S2 registers
  logic               s2_valid, s2_sign, s2_nan_out, s2_invalid, s2_inf, s2_zero;
  logic               s2_ovf, s2_unf, s2_inexact;
  logic [EXP_W-1:0]   s2_exp;
  logic [MAN_W-1:0]   s2_frac;

  // S3 combinational: special-case priority mux
  logic [W-1:0] res_n;
  logic [3:0]   flg_n;

  always_comb begin
    res_n = {s2_sign, s2_exp, s2_frac};
    flg_n = {3'b000, s2_inexact};
    if (s2_nan_out) begin
      res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg_n = {s2_invalid, 3'b000};
    end else if (s2_inf) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n = 4'b0000;
    end else if (s2_zero) begin
      res_n = {s2_sign, {(W-1){1'b0}}};
      flg_n = 4'b0000;
    end else if (s2_ovf) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n = 4'b0101;
    end else if (s2_unf) begin
      res_n = {s2_sign, {(W-1){1'b0}}};
      flg_n = 4'b0011;
    end
  end

  // control: valids and visible outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      s0_valid  <= in_valid;
      s1_valid  <= s0_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      // Bubbles leave the last result in place.
      if (s2_valid) begin
        result <= res_n;
        flags  <= flg_n;
      end
    end
  end

  // datapath: contents behind a zero valid bit are don't-care
  always_ff @(posedge clk) begin
    if (advance) begin
      if (in_valid) begin
        s0_a <= a;
        s0_b <= b;
      end
      s1_sign    <= a_sign ^ b_sign;
      s1_nan_out <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
      s1_invalid <= a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
      s1_inf     <= a_inf || b_inf;
      s1_zero    <= a_zero || b_zero;
      s1_exp     <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
      s1_prod    <= sig_a * sig_b;
      s2_sign    <= s1_sign;
      s2_nan_out <= s1_nan_out;
      s2_invalid <= s1_invalid;
      s2_inf     <= s1_inf;
      s2_zero    <= s1_zero;
      s2_exp     <= e2[EXP_W-1:0];
      s2_frac    <= frac_r;
      s2_ovf     <= (e2 >= EXP_MAX);
      s2_unf     <= (e2 <= $signed({EW{1'b0}}));
      s2_inexact <= inexact_n;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: scoreboard bench for fp_mul_pipe.
//   Single precision DUT checked against directed constants and an
//   integer reference model; a half-precision instance checks parametrisation.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .flags(h_flags)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] sb[$];

  // Reference: exact integer product with explicit nearest-even rounding.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, xnan, ynan, xinf, yinf, xzero, yzero, inv;
    longint unsigned p, keep, rem, half;
    int sh, e;
    s     = x[31] ^ y[31];
    xzero = (x[30:23] == 8'h00);
    yzero = (y[30:23] == 8'h00);
    xinf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yinf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    xnan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    ynan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    if (xnan || ynan || (xinf && yzero) || (xzero && yinf)) begin
      inv = (xinf && yzero) || (xzero && yinf) || (xnan && !x[22]) || (ynan && !y[22]);
      return {inv, 3'b000, 32'h7FC00000};
    end
    if (xinf || yinf) return {4'h0, s, 8'hFF, 23'h0};
    if (xzero || yzero) return {4'h0, s, 31'h0};
    p    = {40'h0, 1'b1, x[22:0]} * {40'h0, 1'b1, y[22:0]};
    sh   = p[47] ? 24 : 23;
    e    = int'(x[30:23]) + int'(y[30:23]) - 127 + (sh - 23);
    keep = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 64'd0), s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [31:0] v;
    k = $urandom_range(0, 15);
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    case (k)
      0: v[30:23] = 8'hFF;
      1: v[30:23] = 8'h00;
      2: v[30:23] = 8'($urandom_range(230, 254));
      3: v[30:23] = 8'($urandom_range(1, 30));
      default: ;
    endcase
    return v;
  endfunction

  // Output-side scoreboard: compare on every output transfer.
  always @(negedge clk) begin
    logic [35:0] exp_v;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got flags=%h result=%h with nothing outstanding", flags, result);
      end else begin
        exp_v = sb.pop_front();
        if ({flags, result} !== exp_v) begin
          n_bad++;
          $display("FAIL sb_result: got flags=%h result=%h, required flags=%h result=%h",
                   flags, result, exp_v[35:32], exp_v[31:0]);
        end
      end
    end
  end

  // Present one operand pair, push its expected result at the transfer edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [35:0] e);
    int waited = 0;
    a = x;
    b = y;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 200 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", tag, sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h required 00000000", result); end
    n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h required 0", flags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (h_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_half_out_valid: got %b required 0", h_out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send(32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});
    send(32'hC0000000, 32'h40400000, {4'h0, 32'hC0C00000});
    send(32'h3FC00000, 32'h3FC00000, {4'h0, 32'h40100000});
    drain("basic");
  endtask

  task automatic test_rounding;
    out_ready = 1'b1;
    send(32'h3F800001, 32'h3F800001, {4'h1, 32'h3F800002});
    // 1.5*(1+u) lands halfway, odd keep -> up; 1.5*(1+3u) halfway, even -> down
    send(32'h3F800001, 32'h3FC00000, {4'h1, 32'h3FC00002});
    send(32'h3F800003, 32'h3FC00000, {4'h1, 32'h3FC00004});
    send(32'h3FFFFFFF, 32'h3FFFFFFF, {4'h1, 32'h407FFFFE});
    drain("rounding");
  endtask

  task automatic test_specials;
    out_ready = 1'b1;
    send(32'h7F800000, 32'h00000000, {4'h8, 32'h7FC00000});
    send(32'h7F800000, 32'hC0000000, {4'h0, 32'hFF800000});
    send(32'h7FC00000, 32'h3F800000, {4'h0, 32'h7FC00000});
    send(32'h7F800001, 32'h3F800000, {4'h8, 32'h7FC00000});
    send(32'h80000000, 32'h3F800000, {4'h0, 32'h80000000});
    send(32'h00000001, 32'h3F800000, {4'h0, 32'h00000000});
    drain("specials");
  endtask

  task automatic test_range;
    out_ready = 1'b1;
    send(32'h7F000000, 32'h7F000000, {4'h5, 32'h7F800000});
    send(32'h00800000, 32'h00800000, {4'h3, 32'h00000000});
    drain("range");
  endtask

  task automatic test_latency;
    int lat = 0;
    out_ready = 1'b1;
    send(32'h40000000, 32'h40000000, {4'h0, 32'h40800000});
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL latency: got %0d cycles required 3", lat); end
    drain("latency");
  endtask

  task automatic test_stall;
    logic [31:0] held_r;
    logic [3:0]  held_f;
    int          n = 0;
    out_ready = 1'b0;
    send(32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});
    send(32'h3FC00000, 32'h3FC00000, {4'h0, 32'h40100000});
    send(32'hBF800000, 32'h40000000, {4'h0, 32'hC0000000});
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid: got %b required 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
    n_cmp++;
    if ({flags, result} !== {4'h0, 32'h40C00000}) begin
      n_bad++; $display("FAIL stall_front: got %h/%h required 0/40c00000", flags, result);
    end
    held_r = result;
    held_f = flags;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== held_r || flags !== held_f) begin
      n_bad++;
      $display("FAIL stall_hold: got valid=%b %h/%h required valid=1 %h/%h", out_valid, flags, result, held_f, held_r);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready_held: got %b required 0", in_ready); end
    out_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_back_to_back;
    bit done = 1'b0;
    fork
      begin
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
          x = rand_op();
          y = rand_op();
          send(x, y, ref_mul(x, y));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("back_to_back");
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    out_ready = 1'b1;
    send(32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});
    send(32'h3FC00000, 32'h3FC00000, {4'h0, 32'h40100000});
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b required 1", in_ready); end
    rst = 1'b0;
    sb.delete();
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale: stale out_valid seen=%b required 0", seen); end
    send(32'h40400000, 32'h40400000, {4'h0, 32'h41100000});
    drain("rstmid");
  endtask

  task automatic test_half;
    logic [15:0] xs[2];
    logic [15:0] ys[2];
    logic [19:0] es[2];
    int          n;
    xs[0] = 16'h4000; ys[0] = 16'h4200; es[0] = {4'h0, 16'h4600};
    xs[1] = 16'h7800; ys[1] = 16'h7800; es[1] = {4'h5, 16'h7C00};
    h_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      h_a = xs[i];
      h_b = ys[i];
      h_in_valid = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      n = 0;
      while (!h_out_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      n_cmp++;
      if ({h_flags, h_result} !== es[i] || h_out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL half_%0d: got valid=%b %h/%h required valid=1 %h/%h",
                 i, h_out_valid, h_flags, h_result, es[i][19:16], es[i][15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_range();
    test_latency();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_half();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
